gbus_wr_collector: RTL and testbench
====================================

// Module: gbus_wr_collector
// PURPOSE
//  Receiving end of the head gbus write port (gbus_addr_delay1/gbus_wen_delay1/gbus_wdata_delay1) for a two-head pair.
//  Heads cannot be back-pressured, so each head's beats land in a per-head FIFO.
//  A round-robin arbiter drains at most one beat per cycle into the single global SRAM write port.
//  Counts committed writes against a programmed expectation and pulses done when complete.
// PARAMETERS
//  FIFO_DEPTH  4                  entries per head FIFO (power of 2, >=2)
//  DATA_WIDTH  `GBUS_DATA_WIDTH   gbus / SRAM write data width
//  CNT_WIDTH   16                 width of expected and committed write counters
// PORTS
//  clk           in   1                  clock
//  rst_n         in   1                  asynchronous active-low reset
//  in_addr_0     in   $bits(BUS_ADDR)    head 0 gbus address (BUS_ADDR, forwarded unmodified)
//  in_wen_0      in   1                  head 0 write strobe, one beat per cycle high
//  in_wdata_0    in   DATA_WIDTH         head 0 write data
//  in_addr_1     in   $bits(BUS_ADDR)    head 1 gbus address
//  in_wen_1      in   1                  head 1 write strobe
//  in_wdata_1    in   DATA_WIDTH         head 1 write data
//  expect_vld    in   1                  pulse: load expect_cnt, zero commit counter, arm
//  expect_cnt    in   CNT_WIDTH          number of SRAM writes expected for this operation
//  clear         in   1                  pulse: synchronous flush of all state
//  sram_wen      out  1                  global SRAM write enable (registered)
//  sram_waddr    out  $bits(BUS_ADDR)    global SRAM write address (BUS_ADDR, registered)
//  sram_wdata    out  DATA_WIDTH         global SRAM write data (registered)
//  sram_src      out  1                  head index of the current sram_* beat
//  done          out  1                  1-cycle pulse when committed count reaches expectation
//  overflow      out  2                  sticky per-head FIFO overflow flag, bit k = head k
//  busy          out  1                  any FIFO non-empty or sram_wen high
// BEHAVIOUR
//  - Reset: FIFOs empty; all outputs 0; counters 0; disarmed; rr_last=1, so head 0 wins the first tie.
//  - Push: in_wen_k sampled at edge N writes {addr,data} into FIFO k.
//  - Pop: the pop decision is made from FIFO state after edge N; the sram_* registers load at edge N+1.
//  - Latency: a beat written into an empty FIFO at edge N drives sram_wen=1 for the cycle after edge N+1.
//  - Arbitration: one FIFO non-empty -> pop it. Both non-empty -> pop the head != rr_last.
//    rr_last is updated to the granted head on every pop.
//  - No pop in a cycle -> sram_wen=0. sram_waddr, sram_wdata and sram_src hold their last values.
//  - Full FIFO with push and pop in the same cycle: push accepted, occupancy unchanged.
//  - Full FIFO with push and no pop: beat dropped, overflow[k] set; the flag holds until clear or reset.
//  - Beats from one head are committed in arrival order. There is no ordering guarantee across heads.
//  - Commit counter increments on every cycle with sram_wen=1. It wraps at 2^CNT_WIDTH and is not saturated.
//  - Armed and (count+1)==expect on a sram_wen cycle: done=1 in the next cycle, then disarm.
//  - expect_cnt==0: done pulses the cycle after expect_vld.
//  - expect_vld while armed: reload expect, zero the count and re-arm. A sram_wen in the same cycle is not counted.
//  - Unarmed: writes are still committed and counted, but done never fires.
//  - clear: at the next edge, FIFOs empty, sram_wen=0, overflow=0, count=0, disarmed, rr_last=1.
//    Pushes in the clear cycle are dropped without setting overflow.
//    If expect_vld and clear are high together, expect_vld is ignored.
//  - Async reset mid-operation discards all buffered beats with no partial write. sram_wen=0 immediately.
// TESTING
//  1. Single beat: head0 A=0x10,D=0xAA at edge 5 -> sram_wen=1 after edge 6 with addr 0x10, data 0xAA, src=0.
//  2. Simultaneous beats: both heads write every cycle for 4 cycles ->
//     commits alternate src 0,1,0,1,... for 8 beats; FIFO_DEPTH=4 gives no overflow.
//  3. Sustained dual writes for 10 cycles (DEPTH=4) -> overflow sets on the first drop.
//     Committed beats per head stay in order with no duplicates; overflow stays set until clear.
//  4. expect_cnt=6 armed, 6 mixed beats -> done pulses exactly once, one cycle after the 6th sram_wen.
//     expect_cnt=0 -> done pulses the cycle after expect_vld.
//  5. clear asserted with 3 beats buffered and wen_0 high -> next cycle busy=0, sram_wen=0, overflow=0.
//     The dropped beat never appears on sram_*.
//  6. rst_n low mid-burst -> all outputs 0 asynchronously. After release, a new beat commits with 2-cycle latency.

Source files
------------

// File: rtl/gbus_wr_collector.sv
// Collects gbus write beats from two heads into per-head FIFOs and drains
// them round-robin onto one SRAM write port, counting committed writes.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_addr/wen/wdata_k head k gbus beat (k = 0,1), never back-pressured
//   expect_vld/cnt      load write expectation, zero count, arm
//   clear               synchronous flush of all state
//   sram_wen/waddr/...  registered SRAM write port, sram_src = head index
//   done                1-cycle pulse when count reaches expectation
//   overflow            sticky per-head drop flag
//   busy                any FIFO non-empty or write in flight

`ifndef GBUS_DATA_WIDTH
`define GBUS_DATA_WIDTH 32
`endif

module gbus_wr_collector #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = `GBUS_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16,
  // width of the opaque BUS_ADDR field, forwarded unmodified
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] in_addr_0,
  input  logic                  in_wen_0,
  input  logic [DATA_WIDTH-1:0] in_wdata_0,
  input  logic [ADDR_WIDTH-1:0] in_addr_1,
  input  logic                  in_wen_1,
  input  logic [DATA_WIDTH-1:0] in_wdata_1,
  input  logic                  expect_vld,
  input  logic [CNT_WIDTH-1:0]  expect_cnt,
  input  logic                  clear,
  output logic                  sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_waddr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  sram_src,
  output logic                  done,
  output logic [1:0]            overflow,
  output logic                  busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef logic [EW-1:0] entry_t;

  entry_t          mem_q [2][FIFO_DEPTH];
  logic [AW:0]     wr_q  [2];
  logic [AW:0]     rd_q  [2];
  entry_t          din   [2];
  logic [1:0]      wen;
  logic [1:0]      full;
  logic [1:0]      empty;
  logic [1:0]      push;
  logic [1:0]      drop;
  logic [1:0]      pop;
  logic            grant;
  logic            any_ne;
  entry_t          pop_data;

  logic                  sram_wen_q;
  logic [ADDR_WIDTH-1:0] sram_waddr_q;
  logic [DATA_WIDTH-1:0] sram_wdata_q;
  logic                  sram_src_q;
  logic                  rr_last_q;
  logic [1:0]            ovf_q;

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  exp_q, exp_d;
  logic                  armed_q, armed_d;
  logic                  done_q, done_d;

  assign wen    = {in_wen_1, in_wen_0};
  assign din[0] = {in_addr_0, in_wdata_0};
  assign din[1] = {in_addr_1, in_wdata_1};

  // extra pointer bit distinguishes full from empty
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      empty[k] = (wr_q[k] == rd_q[k]);
      full[k]  = (wr_q[k][AW] != rd_q[k][AW]) &&
                 (wr_q[k][AW-1:0] == rd_q[k][AW-1:0]);
    end
  end

  // round-robin: on a tie the head that did not win last time goes
  always_comb begin
    grant = 1'b0;
    if (!empty[0] && !empty[1]) begin
      grant = ~rr_last_q;
    end else if (!empty[1]) begin
      grant = 1'b1;
    end
  end

  assign any_ne = ~(empty[0] & empty[1]);
  assign pop[0] = any_ne & ~clear & ~grant;
  assign pop[1] = any_ne & ~clear & grant;

  // a full FIFO still accepts a push when it is popped that cycle
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      push[k] = wen[k] & ~clear & (~full[k] | pop[k]);
      drop[k] = wen[k] & ~clear & full[k] & ~pop[k];
    end
  end

  assign pop_data = grant ? mem_q[1][rd_q[1][AW-1:0]]
                          : mem_q[0][rd_q[0][AW-1:0]];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) begin
        mem_q[k][wr_q[k][AW-1:0]] <= din[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        wr_q[k] <= '0;
        rd_q[k] <= '0;
      end
    end else if (clear) begin
      for (int k = 0; k < 2; k++) begin
        wr_q[k] <= '0;
        rd_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        wr_q[k] <= wr_q[k] + (AW+1)'(push[k]);
        rd_q[k] <= rd_q[k] + (AW+1)'(pop[k]);
      end
    end
  end

  // expect_vld takes priority over a same-cycle commit
  always_comb begin
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    armed_d = armed_q;
    done_d  = 1'b0;
    if (expect_vld) begin
      exp_d   = expect_cnt;
      cnt_d   = '0;
      armed_d = (expect_cnt != '0);
      done_d  = (expect_cnt == '0);
    end else if (sram_wen_q) begin
      cnt_d = cnt_q + CNT_ONE;
      if (armed_q && (cnt_d == exp_q)) begin
        done_d  = 1'b1;
        armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_wen_q   <= 1'b0;
      sram_waddr_q <= '0;
      sram_wdata_q <= '0;
      sram_src_q   <= 1'b0;
      rr_last_q    <= 1'b1;
      ovf_q        <= '0;
      cnt_q        <= '0;
      exp_q        <= '0;
      armed_q      <= 1'b0;
      done_q       <= 1'b0;
    end else if (clear) begin
      sram_wen_q   <= 1'b0;
      sram_waddr_q <= '0;
      sram_wdata_q <= '0;
      sram_src_q   <= 1'b0;
      rr_last_q    <= 1'b1;
      ovf_q        <= '0;
      cnt_q        <= '0;
      exp_q        <= '0;
      armed_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sram_wen_q <= any_ne;
      if (any_ne) begin
        {sram_waddr_q, sram_wdata_q} <= pop_data;
        sram_src_q <= grant;
        rr_last_q  <= grant;
      end
      ovf_q   <= ovf_q | drop;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      armed_q <= armed_d;
      done_q  <= done_d;
    end
  end

  assign sram_wen   = sram_wen_q;
  assign sram_waddr = sram_waddr_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_src   = sram_src_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign busy       = any_ne | sram_wen_q;

endmodule

// File: tb/tb_gbus_wr_collector.sv
// Directed self-checking bench for gbus_wr_collector.
// Linear stimulus, immediate assertions at each comparison.

module tb_gbus_wr_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_addr_0, in_addr_1;
  logic        in_wen_0, in_wen_1;
  logic [31:0] in_wdata_0, in_wdata_1;
  logic        expect_vld;
  logic [15:0] expect_cnt;
  logic        clear;
  logic        sram_wen;
  logic [15:0] sram_waddr;
  logic [31:0] sram_wdata;
  logic        sram_src;
  logic        done;
  logic [1:0]  overflow;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  gbus_wr_collector #(
    .FIFO_DEPTH(4),
    .DATA_WIDTH(32),
    .CNT_WIDTH (16),
    .ADDR_WIDTH(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_addr_0 (in_addr_0),
    .in_wen_0  (in_wen_0),
    .in_wdata_0(in_wdata_0),
    .in_addr_1 (in_addr_1),
    .in_wen_1  (in_wen_1),
    .in_wdata_1(in_wdata_1),
    .expect_vld(expect_vld),
    .expect_cnt(expect_cnt),
    .clear     (clear),
    .sram_wen  (sram_wen),
    .sram_waddr(sram_waddr),
    .sram_wdata(sram_wdata),
    .sram_src  (sram_src),
    .done      (done),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // head0 beat i: addr 1000+i data A0000000+i; head1: 2000+i / B0000000+i
  task automatic drive(input logic w0, input logic w1, input int i);
    in_wen_0   = w0;
    in_wen_1   = w1;
    in_addr_0  = 16'h1000 + 16'(i);
    in_wdata_0 = 32'hA000_0000 + 32'(i);
    in_addr_1  = 16'h2000 + 16'(i);
    in_wdata_1 = 32'hB000_0000 + 32'(i);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    int j;
    int i0;
    int i1;
    int nwen;
    logic [31:0] ed;
    int exp0 [9];
    int exp1 [8];
    exp0 = '{0, 1, 2, 3, 4, 5, 6, 7, 9};
    exp1 = '{0, 1, 2, 3, 4, 5, 6, 8};

    rst_n      = 1'b0;
    expect_vld = 1'b0;
    expect_cnt = '0;
    clear      = 1'b0;
    drive(1'b0, 1'b0, 0);
    #2;
    check("rst_wen", 64'(sram_wen), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_addr", 64'(sram_waddr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // single beat, 2-edge latency
    in_wen_0   = 1'b1;
    in_addr_0  = 16'h0010;
    in_wdata_0 = 32'h0000_00AA;
    step();
    in_wen_0 = 1'b0;
    check("t1_wen_n", 64'(sram_wen), 64'(0));
    check("t1_busy_n", 64'(busy), 64'(1));
    step();
    check("t1_wen", 64'(sram_wen), 64'(1));
    check("t1_addr", 64'(sram_waddr), 64'(16'h0010));
    check("t1_data", 64'(sram_wdata), 64'(32'hAA));
    check("t1_src", 64'(sram_src), 64'(0));
    step();
    check("t1_wen_off", 64'(sram_wen), 64'(0));
    check("t1_busy_off", 64'(busy), 64'(0));
    check("t1_addr_hold", 64'(sram_waddr), 64'(16'h0010));

    // both heads 4 cycles: commits edges 2..9 alternate 0,1,...
    do_clear();
    for (int e = 1; e <= 11; e++) begin
      drive(e <= 4, e <= 4, e - 1);
      step();
      check("t2_wen", 64'(sram_wen), 64'(e >= 2 && e <= 9));
      if (e >= 2 && e <= 9) begin
        j = e - 2;
        ed = (j % 2 == 1) ? 32'hB000_0000 + 32'(j / 2)
                          : 32'hA000_0000 + 32'(j / 2);
        check("t2_src", 64'(sram_src), 64'(j % 2));
        check("t2_data", 64'(sram_wdata), 64'(ed));
      end
    end
    check("t2_ovf", 64'(overflow), 64'(0));

    // sustained 10 cycles: drops head1#7, head0#8, head1#9
    do_clear();
    i0 = 0;
    i1 = 0;
    for (int e = 1; e <= 20; e++) begin
      drive(e <= 10, e <= 10, e - 1);
      step();
      if (e == 7) check("t3_ovf7", 64'(overflow), 64'(2'b00));
      if (e == 8) check("t3_ovf8", 64'(overflow), 64'(2'b10));
      if (e == 9) check("t3_ovf9", 64'(overflow), 64'(2'b11));
      if (sram_wen && !sram_src) begin
        if (i0 < 9) begin
          check("t3_h0", 64'(sram_wdata),
                64'(32'hA000_0000 + 32'(exp0[i0])));
          check("t3_h0a", 64'(sram_waddr),
                64'(16'h1000 + 16'(exp0[i0])));
        end
        i0++;
      end
      if (sram_wen && sram_src) begin
        if (i1 < 8) begin
          check("t3_h1", 64'(sram_wdata),
                64'(32'hB000_0000 + 32'(exp1[i1])));
        end
        i1++;
      end
    end
    check("t3_n0", 64'(i0), 64'(9));
    check("t3_n1", 64'(i1), 64'(8));
    check("t3_ovf_hold", 64'(overflow), 64'(2'b11));
    do_clear();
    check("t3_ovf_clr", 64'(overflow), 64'(0));

    // expect 6: three dual pushes, commits edges 2..7, done at 8
    expect_vld = 1'b1;
    expect_cnt = 16'd6;
    step();
    expect_vld = 1'b0;
    check("t4_done0", 64'(done), 64'(0));
    nwen = 0;
    for (int e = 1; e <= 10; e++) begin
      drive(e <= 3, e <= 3, e - 1);
      step();
      if (sram_wen) nwen++;
      check("t4_done", 64'(done), 64'(e == 8));
    end
    check("t4_nwen", 64'(nwen), 64'(6));
    expect_vld = 1'b1;
    expect_cnt = 16'd0;
    step();
    expect_vld = 1'b0;
    check("t4_zero", 64'(done), 64'(1));
    step();
    check("t4_zero_off", 64'(done), 64'(0));
    drive(1'b1, 1'b0, 40);
    step();
    drive(1'b0, 1'b0, 0);
    for (int e = 0; e < 3; e++) begin
      step();
      check("t4_unarmed", 64'(done), 64'(0));
    end

    // clear with 3 beats buffered and a push pending
    do_clear();
    drive(1'b1, 1'b1, 0);
    step();
    drive(1'b1, 1'b1, 1);
    step();
    check("t5_pre_busy", 64'(busy), 64'(1));
    drive(1'b1, 1'b0, 0);
    in_addr_0  = 16'h005D;
    in_wdata_0 = 32'h0000_DEAD;
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(1'b0, 1'b0, 0);
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_wen", 64'(sram_wen), 64'(0));
    check("t5_ovf", 64'(overflow), 64'(0));
    for (int e = 0; e < 4; e++) begin
      step();
      check("t5_no_ghost", 64'(sram_wen), 64'(0));
    end

    // async reset mid-burst
    drive(1'b1, 1'b1, 0);
    step();
    drive(1'b1, 1'b1, 1);
    step();
    check("t6_pre", 64'(sram_wen), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_wen", 64'(sram_wen), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_addr", 64'(sram_waddr), 64'(0));
    check("t6_data", 64'(sram_wdata), 64'(0));
    check("t6_src", 64'(sram_src), 64'(0));
    drive(1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_wen_1   = 1'b1;
    in_addr_1  = 16'h0066;
    in_wdata_1 = 32'h0000_0077;
    step();
    in_wen_1 = 1'b0;
    check("t6_lat_n", 64'(sram_wen), 64'(0));
    step();
    check("t6_lat", 64'(sram_wen), 64'(1));
    check("t6_lat_a", 64'(sram_waddr), 64'(16'h0066));
    check("t6_lat_d", 64'(sram_wdata), 64'(32'h77));
    check("t6_lat_s", 64'(sram_src), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
